// File: rtl/or_chk_pkg.sv
// Shared definitions for the OR response checker: FSM encoding, parameter
// ranges and the delay-line entry layout.
package or_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 8;
  localparam int NVEC_MIN   = 1;
  localparam int NVEC_MAX   = 255;

  // Vector counters are sized for the largest legal run length.
  localparam int VCNT_W = $clog2(NVEC_MAX + 1);

  typedef struct packed {
    logic valid;
    logic expected;
    logic a;
    logic b;
  } dly_entry_t;

endpackage

// File: rtl/or_chk_dly.sv
// SETTLE-deep shift register carrying {valid, expected, a, b} from accept to
// compare; it advances every cycle whether or not a new entry is pushed.
module or_chk_dly
  import or_chk_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  dly_entry_t din,
  output dly_entry_t dout
);

  dly_entry_t line_q [SETTLE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SETTLE; i++) line_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < SETTLE; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= push ? din : '0;
      for (int i = 1; i < SETTLE; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign dout = line_q[SETTLE-1];

endmodule

// File: rtl/or_resp_checker.sv
// Run-based checker for a 2-input OR DUT: compares y against a|b SETTLE cycles
// after each accepted stimulus. Define OR_RESP_CHK_COVER_EN for the cov port.
module or_resp_checker
  import or_chk_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int NVEC   = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_vld,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
`ifdef OR_RESP_CHK_COVER_EN
  ,
  output logic [3:0]       cov
`endif
);

  // Out-of-range parameters are clamped to the legal range.
  localparam int SETTLE_EFF = (SETTLE < SETTLE_MIN) ? SETTLE_MIN :
                              (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
  localparam int NVEC_EFF   = (NVEC < NVEC_MIN) ? NVEC_MIN :
                              (NVEC > NVEC_MAX) ? NVEC_MAX : NVEC;
  localparam logic [VCNT_W-1:0] NVEC_CNT = VCNT_W'(NVEC_EFF);
  localparam logic [CNT_W-1:0]  ERR_MAX  = '1;

  state_t            state, state_nxt;
  logic              clr, accept, cmp, mismatch;
  logic [VCNT_W-1:0] acc_cnt, vec_cnt;
  dly_entry_t        push_entry, dly_out;

  assign clr        = (state != CHECK) && start;
  assign accept     = (state == CHECK) && in_vld && (acc_cnt < NVEC_CNT);
  assign push_entry = '{valid: 1'b1, expected: a | b, a: a, b: b};
  assign cmp        = (state == CHECK) && dly_out.valid;
  assign mismatch   = cmp && (y != dly_out.expected);

  or_chk_dly #(
    .SETTLE (SETTLE_EFF)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .push (accept),
    .din  (push_entry),
    .dout (dly_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The run ends one edge after the last compare has been counted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = CHECK;
      CHECK:      if (vec_cnt == NVEC_CNT) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt    <= '0;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      acc_cnt    <= '0;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + VCNT_W'(1);
      if (cmp)    vec_cnt <= vec_cnt + VCNT_W'(1);
      if (mismatch) begin
        err_sticky <= 1'b1;
        if (err_cnt != ERR_MAX) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (state == CHECK);
  assign done = (state == DONE);

`ifdef OR_RESP_CHK_COVER_EN
  // Coverage records the {a,b} pair of each entry as it is compared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cov <= '0;
    else if (clr) cov <= '0;
    else if (cmp) cov[{dly_out.a, dly_out.b}] <= 1'b1;
  end

  assign pass = done && !err_sticky && (&cov);
`else
  logic unused_ab;
  assign unused_ab = dly_out.a ^ dly_out.b;

  assign pass = done && !err_sticky;
`endif

endmodule

// File: tb/tb_or_resp_checker.sv
// Randomized self-checking bench for or_resp_checker with a queue-based
// reference model; honours OR_RESP_CHK_COVER_EN like the design.
module tb_or_resp_checker;

  localparam int SETTLE  = 2;
  localparam int NVEC    = 4;
  localparam int CNT_W   = 2;
  localparam int ERR_MAX = (1 << CNT_W) - 1;
`ifdef OR_RESP_CHK_COVER_EN
  localparam bit COV_EN = 1'b1;
`else
  localparam bit COV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start, in_vld, a, b, y;
  logic             busy, done, pass, err_sticky;
  logic [CNT_W-1:0] err_cnt;
`ifdef OR_RESP_CHK_COVER_EN
  logic [3:0]       cov;
`endif

  or_resp_checker #(
    .SETTLE (SETTLE),
    .NVEC   (NVEC),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_vld     (in_vld),
    .a          (a),
    .b          (b),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
`ifdef OR_RESP_CHK_COVER_EN
    ,
    .cov        (cov)
`endif
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int fault_mode = 0;
  bit or_hist [int];

  typedef enum {M_IDLE, M_CHECK, M_DONE} mphase_t;
  typedef struct {
    int       due;
    bit       expv;
    bit [1:0] ab;
  } pend_t;

  pend_t   pend[$];
  mphase_t m_phase  = M_IDLE;
  int      m_acc    = 0;
  int      m_cmp    = 0;
  int      m_err    = 0;
  bit      m_sticky = 1'b0;
  bit [3:0] m_cov   = 4'h0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void modelClear();
    pend.delete();
    m_acc    = 0;
    m_cmp    = 0;
    m_err    = 0;
    m_sticky = 1'b0;
    m_cov    = 4'h0;
  endfunction

  function automatic bit faultY(input bit v);
    case (fault_mode)
      1:       return 1'b0;
      2:       return ~v;
      3:       return v ^ ($urandom_range(0, 3) == 0);
      default: return v;
    endcase
  endfunction

  // Reference model: a run accepts at most NVEC vectors, each one is judged
  // SETTLE edges later, and the run is over one edge after the NVEC-th verdict.
  always @(posedge clk) begin
    pend_t p;
    cyc++;
    if (rst) begin
      modelClear();
      m_phase = M_IDLE;
    end else begin
      case (m_phase)
        M_IDLE, M_DONE: begin
          if (start) begin
            modelClear();
            m_phase = M_CHECK;
          end
        end
        M_CHECK: begin
          if (m_cmp == NVEC) begin
            m_phase = M_DONE;
          end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
              p = pend.pop_front();
              m_cmp++;
              m_cov[p.ab] = 1'b1;
              if (y !== p.expv) begin
                m_sticky = 1'b1;
                if (m_err < ERR_MAX) m_err++;
              end
            end
            if (in_vld && m_acc < NVEC) begin
              pend.push_back('{due: cyc + SETTLE, expv: a | b, ab: {a, b}});
              m_acc++;
            end
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    bit e_busy, e_done, e_pass, e_sticky;
    int e_err;
    bit [3:0] e_cov;
    if (rst) begin
      e_busy = 0; e_done = 0; e_pass = 0; e_sticky = 0; e_err = 0; e_cov = 4'h0;
    end else begin
      e_busy   = (m_phase == M_CHECK);
      e_done   = (m_phase == M_DONE);
      e_sticky = m_sticky;
      e_err    = m_err;
      e_cov    = m_cov;
      e_pass   = e_done && !m_sticky && (!COV_EN || m_cov == 4'hF);
    end
    checkOutput("busy", int'(busy), int'(e_busy));
    checkOutput("done", int'(done), int'(e_done));
    checkOutput("pass", int'(pass), int'(e_pass));
    checkOutput("err_cnt", int'(err_cnt), e_err);
    checkOutput("err_sticky", int'(err_sticky), int'(e_sticky));
`ifdef OR_RESP_CHK_COVER_EN
    checkOutput("cov", int'(cov), int'(e_cov));
`endif
  end

  task automatic applyStimulus(input bit s, input bit v, input bit aa, input bit bb);
    int idx;
    @(posedge clk);
    #1;
    idx    = cyc + 1;
    start  = s;
    in_vld = v;
    a      = aa;
    b      = bb;
    or_hist[idx] = aa | bb;
    y = faultY(or_hist.exists(idx - SETTLE) ? or_hist[idx - SETTLE] : 1'b0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst    = 1'b1;
    start  = 1'b0;
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // vecs holds {a,b} pairs, vector i in bits [2i+1:2i], applied back-to-back.
  task automatic runVectors(input int n, input logic [15:0] vecs);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, vecs[2*i+1], vecs[2*i]);
  endtask

  task automatic waitDone(input int budget, input string name);
    int n = 0;
    while (n < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (done) break;
      n++;
    end
    checkOutput({name, " done reached"}, int'(done), 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit kill;
    bit full_rate;
    rst = 1'b1; start = 1'b0; in_vld = 1'b0; a = 1'b0; b = 1'b0; y = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset pass", int'(pass), 0);
    checkOutput("reset err_cnt", int'(err_cnt), 0);

    // All four combinations against a correct OR.
    fault_mode = 0;
    runVectors(4, 16'hE4);
    waitDone(20, "good4");
    checkOutput("good4 err_cnt", int'(err_cnt), 0);
    checkOutput("good4 pass", int'(pass), 1);
    checkOutput("good4 model err", m_err, 0);
`ifdef OR_RESP_CHK_COVER_EN
    checkOutput("good4 cov", int'(cov), 15);
`endif

    // Output stuck at 0: three of the four vectors expect 1.
    fault_mode = 1;
    runVectors(4, 16'hE4);
    waitDone(20, "stuck0");
    checkOutput("stuck0 err_cnt", int'(err_cnt), 3);
    checkOutput("stuck0 err_sticky", int'(err_sticky), 1);
    checkOutput("stuck0 pass", int'(pass), 0);
    checkOutput("stuck0 model err", m_err, 3);

    // Only 00 and 11: no errors, but coverage is incomplete.
    fault_mode = 0;
    runVectors(4, 16'hCC);
    waitDone(20, "partial");
    checkOutput("partial err_cnt", int'(err_cnt), 0);
`ifdef OR_RESP_CHK_COVER_EN
    checkOutput("partial pass", int'(pass), 0);
    checkOutput("partial cov", int'(cov), 9);
`else
    checkOutput("partial pass", int'(pass), 1);
`endif

    // Inverted output: four mismatches saturate a 2-bit counter at 3.
    fault_mode = 2;
    runVectors(4, 16'hE4);
    waitDone(20, "invert");
    checkOutput("invert err_cnt", int'(err_cnt), 3);
    checkOutput("invert model err", m_err, 3);
    checkOutput("invert pass", int'(pass), 0);

    // Reset mid-run, then a clean run.
    fault_mode = 2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    pulseReset();
    @(negedge clk);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort err_cnt", int'(err_cnt), 0);
    checkOutput("abort err_sticky", int'(err_sticky), 0);
    fault_mode = 0;
    runVectors(4, 16'hE4);
    waitDone(20, "rerun");
    checkOutput("rerun pass", int'(pass), 1);
    checkOutput("rerun err_cnt", int'(err_cnt), 0);

    // in_vld in IDLE and start during CHECK are both ignored.
    pulseReset();
    fault_mode = 2;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    fault_mode = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    waitDone(20, "ignore");
    checkOutput("ignore err_cnt", int'(err_cnt), 0);
    checkOutput("ignore pass", int'(pass), 1);

    // Randomized runs: gaps, faults, stray starts and occasional aborts.
    for (int run = 0; run < 40; run++) begin
      fault_mode = $urandom_range(0, 3);
      kill       = ($urandom_range(0, 7) == 0);
      full_rate  = ($urandom_range(0, 2) == 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 80; n++) begin
        if (kill && n == 3) begin
          pulseReset();
          break;
        end
        applyStimulus($urandom_range(0, 9) == 0,
                      full_rate ? 1'b1 : 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge clk);
        if (done) break;
      end
      if (!kill) checkOutput("random done reached", int'(done), 1);
      for (int n = 0; n < 3; n++)
        applyStimulus(1'b0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
